// File: rtl/demux4_reg16.sv
// 1:4 registered demultiplexer with per-destination one-entry holding slots.
// A full slot back-pressures only transfers steered to it.
module demux4_reg16 #(
    parameter int WIDTH   = 16,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [WIDTH-1:0]   in_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [WIDTH-1:0]   out_data0,
    output logic [WIDTH-1:0]   out_data1,
    output logic [WIDTH-1:0]   out_data2,
    output logic [WIDTH-1:0]   out_data3,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [3:0]       full;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic             accept;
    logic [WIDTH-1:0] hold [4];

    // A full slot may still accept when it drains on the same edge.
    assign in_ready = ~full[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign drain    = full & out_ready;

    always_comb begin
        load = '0;
        if (accept)
            load[in_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            full <= '0;
        else
            full <= (full & ~drain) | load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++)
                hold[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (load[k])
                    hold[k] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (in_valid && !in_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + STALL_W'(1);
    end

    assign out_valid = full;
    assign out_data0 = hold[0];
    assign out_data1 = hold[1];
    assign out_data2 = hold[2];
    assign out_data3 = hold[3];

endmodule
